tt_phase_sequencer: RTL and testbench
=====================================

// Module: tt_phase_sequencer
// PURPOSE
//  Sequences the transistor-tester drive phases for up to two channels. It replaces free-running
//  gated clocks with registered, reset-safe phase outputs.
//  Per channel, one measurement cycle is: DRIVE (complementary half-rate phases), SETTLE, then SAMPLE.
//  SAMPLE runs a req/ack handshake with the shared measurement front-end.
//  Sits between the tester top-level control and the channel drive/measurement datapath.
// PARAMETERS
//  CNT_W      6   width of phase counter and phase_cnt output
//  DRIVE_CYC  11  clk cycles in DRIVE (phi toggling), 1..2**CNT_W-1
//  SETTLE_CYC 8   clk cycles in SETTLE (settle high, phases low), 1..2**CNT_W-1
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      1-cycle request to run one full sequence; ignored while busy
//  abort       in   1      terminate sequence; return to IDLE next cycle
//  sample_ack  in   1      measurement front-end accepted sample_req
//  ch1_phi     out  1      channel 1 drive phase
//  ch1_phib    out  1      channel 1 complementary drive phase
//  ch2_phi     out  1      channel 2 drive phase (0 when CH2 compiled out)
//  ch2_phib    out  1      channel 2 complementary phase (0 when CH2 compiled out)
//  settle      out  1      high in SETTLE states
//  sample_req  out  1      high in SAMPLE states until acknowledged
//  active_ch   out  1      0 = channel 1 phase in progress, 1 = channel 2
//  busy        out  1      high in every state except IDLE
//  done        out  1      1-cycle pulse when the sequence completes normally
//  phase_cnt   out  CNT_W  cycles elapsed in current state; 0 on entry
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counter 0.
//  All outputs are registered; no combinational paths from inputs to outputs.
//  FSM: IDLE -> DRIVE1 -> SETTLE1 -> SAMPLE1 -> DRIVE2 -> SETTLE2 -> SAMPLE2 -> DONE -> IDLE.
//  IDLE: start=1 and abort=0 -> DRIVE1 next cycle; busy rises with DRIVE1.
//  DRIVE: lasts exactly DRIVE_CYC cycles.
//   - phi starts at 1 on entry and toggles every cycle; phib = ~phi.
//   - Both phases are 0 outside DRIVE.
//   - The other channel's phases stay 0.
//  SETTLE: lasts exactly SETTLE_CYC cycles; settle=1 throughout.
//  SAMPLE:
//   - sample_req=1 from entry.
//   - Held until the first cycle sample_ack=1; that cycle is the last in SAMPLE.
//   - sample_req drops on the next edge.
//   - Waits indefinitely for ack. An ack seen outside SAMPLE is ignored.
//  DONE: 1 cycle; done=1, busy=1. Then IDLE.
//  active_ch=1 in DRIVE2/SETTLE2/SAMPLE2; 0 elsewhere.
//  phase_cnt: cleared on each state entry; +1 per cycle.
//   - Saturates at 2**CNT_W-1 (SAMPLE wait).
//   - Never wraps.
//  abort:
//   - In any busy state -> IDLE next edge; all outputs 0; no done.
//   - abort and start together in IDLE: stay IDLE.
//  start while busy: ignored, not queued.
//  Async reset mid-sequence: outputs 0 immediately; IDLE.
//  Elaboration: DRIVE_CYC or SETTLE_CYC outside 1..2**CNT_W-1 -> $error.
// CONFIGURATION
//  TT_CH2_EN defined: full two-channel sequence as above.
//  TT_CH2_EN undefined:
//   - SAMPLE1 -> DONE; DRIVE2/SETTLE2/SAMPLE2 not built.
//   - ch2_phi, ch2_phib and active_ch tied 0.
// STRUCTURE
//  Package tt_pkg: state enum tt_seq_state_e; default DRIVE_CYC/SETTLE_CYC localparams.
//  One sub-module: tt_phase_gen.
//   - Instantiated per channel; enable -> registered phi/phib toggle.
//   - phi=1 on first enabled cycle; both 0 when disabled.
// TESTING
//  1. Reset: rst_n=0 mid-DRIVE1 -> all outputs 0 asynchronously; IDLE after release.
//  2. Nominal (defaults, CH2 on): start, ack 3 cycles after req ->
//   - ch1_phi = 1,0,1,... over 11 cycles; settle 8 cycles; sample_req 4 cycles.
//   - Same for ch2; done pulse; busy 1 + 2*(11+8+4) = 47 cycles.
//  3. Ack already high on SAMPLE entry -> SAMPLE lasts 1 cycle; sample_req high 1 cycle.
//  4. abort at DRIVE2 cycle 5 -> IDLE next edge; no done; start next cycle accepted.
//  5. start while busy, and start+abort together in IDLE -> both ignored; sequence unchanged.
//  6. TT_CH2_EN undefined: start -> DONE right after SAMPLE1; ch2_phi/ch2_phib/active_ch never 1.

Source files
------------

// File: rtl/tt_phase_sequencer_pkg.sv
// Shared types and default timing for the transistor-tester phase sequencer.
// The full state set is declared here; the second channel is built only when TT_CH2_EN is defined.
package tt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE1,
        ST_SETTLE1,
        ST_SAMPLE1,
        ST_DRIVE2,
        ST_SETTLE2,
        ST_SAMPLE2,
        ST_DONE
    } tt_seq_state_e;

    localparam int TT_CNT_W_DEF      = 6;
    localparam int TT_DRIVE_CYC_DEF  = 11;
    localparam int TT_SETTLE_CYC_DEF = 8;

endpackage

// File: rtl/tt_phase_sequencer_if.sv
// Control, handshake and phase-output bundle of the phase sequencer.
// Handshake: sample_req is held high until the first cycle sample_ack is high; that cycle completes the transfer.
interface tt_phase_sequencer_if #(
    parameter int CNT_W = 6
);
    import tt_pkg::*;

    logic             start;
    logic             abort;
    logic             sample_ack;
    logic             ch1_phi;
    logic             ch1_phib;
    logic             ch2_phi;
    logic             ch2_phib;
    logic             settle;
    logic             sample_req;
    logic             active_ch;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] phase_cnt;
    tt_seq_state_e    dbg_state;

    modport slave (
        input  start, abort, sample_ack,
        output ch1_phi, ch1_phib, ch2_phi, ch2_phib, settle, sample_req,
        output active_ch, busy, done, phase_cnt, dbg_state
    );

    modport master (
        output start, abort, sample_ack,
        input  ch1_phi, ch1_phib, ch2_phi, ch2_phib, settle, sample_req,
        input  active_ch, busy, done, phase_cnt, dbg_state
    );

endinterface

// File: rtl/tt_phase_sequencer_phase_gen.sv
// Registered complementary half-rate phase pair for one drive channel.
// phi is 1 on the first enabled cycle and toggles each cycle after; both phases are 0 while disabled.
module tt_phase_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic phi,
    output logic phib
);

    // phi is 0 whenever disabled, so inverting it yields the required 1 on the first enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi  <= 1'b0;
            phib <= 1'b0;
        end else if (en) begin
            phi  <= ~phi;
            phib <= phi;
        end else begin
            phi  <= 1'b0;
            phib <= 1'b0;
        end
    end

endmodule

// File: rtl/tt_phase_sequencer.sv
// Drive / settle / sample phase sequencer for one or two tester channels, all outputs registered.
// Define TT_CH2_EN to build the second channel; otherwise SAMPLE1 goes straight to DONE.
module tt_phase_sequencer
    import tt_pkg::*;
#(
    parameter int CNT_W      = TT_CNT_W_DEF,
    parameter int DRIVE_CYC  = TT_DRIVE_CYC_DEF,
    parameter int SETTLE_CYC = TT_SETTLE_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tt_phase_sequencer_if.slave   bus
);

    localparam int               CNT_MAX_I   = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] DRIVE_LAST  = CNT_W'(DRIVE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    if (DRIVE_CYC < 1 || DRIVE_CYC > CNT_MAX_I) begin : g_bad_drive
        $error("tt_phase_sequencer: DRIVE_CYC out of range 1..2**CNT_W-1");
    end
    if (SETTLE_CYC < 1 || SETTLE_CYC > CNT_MAX_I) begin : g_bad_settle
        $error("tt_phase_sequencer: SETTLE_CYC out of range 1..2**CNT_W-1");
    end

    tt_seq_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             settle_q, req_q, active_q, busy_q, done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.start) state_d = ST_DRIVE1;
            ST_DRIVE1:  if (cnt_q == DRIVE_LAST) state_d = ST_SETTLE1;
            ST_SETTLE1: if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE1;
`ifdef TT_CH2_EN
            ST_SAMPLE1: if (bus.sample_ack) state_d = ST_DRIVE2;
            ST_DRIVE2:  if (cnt_q == DRIVE_LAST) state_d = ST_SETTLE2;
            ST_SETTLE2: if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE2;
            ST_SAMPLE2: if (bus.sample_ack) state_d = ST_DONE;
`else
            ST_SAMPLE1: if (bus.sample_ack) state_d = ST_DONE;
`endif
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        // abort wins everywhere, including a start in the same IDLE cycle.
        if (bus.abort) state_d = ST_IDLE;
    end

    // The counter restarts on every state change and rests at 0 while idle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q || state_d == ST_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Flags are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= 1'b0;
            req_q    <= 1'b0;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            settle_q <= (state_d == ST_SETTLE1) || (state_d == ST_SETTLE2);
            req_q    <= (state_d == ST_SAMPLE1) || (state_d == ST_SAMPLE2);
            active_q <= (state_d == ST_DRIVE2) || (state_d == ST_SETTLE2) ||
                        (state_d == ST_SAMPLE2);
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
        end
    end

    tt_phase_gen u_ch1_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_d == ST_DRIVE1),
        .phi   (bus.ch1_phi),
        .phib  (bus.ch1_phib)
    );

`ifdef TT_CH2_EN
    tt_phase_gen u_ch2_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_d == ST_DRIVE2),
        .phi   (bus.ch2_phi),
        .phib  (bus.ch2_phib)
    );
    assign bus.active_ch = active_q;
`else
    assign bus.ch2_phi   = 1'b0;
    assign bus.ch2_phib  = 1'b0;
    assign bus.active_ch = 1'b0;
    logic unused_active;
    assign unused_active = active_q;
`endif

    assign bus.settle     = settle_q;
    assign bus.sample_req = req_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.phase_cnt  = cnt_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_tt_phase_sequencer.sv
// Self-checking bench for tt_phase_sequencer; follows TT_CH2_EN to pick the one- or two-channel sequence.
module tb_tt_phase_sequencer;
    import tt_pkg::*;

    localparam int CNT_W      = 6;
    localparam int DRIVE_CYC  = 11;
    localparam int SETTLE_CYC = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
    localparam int W          = 9 + CNT_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tt_phase_sequencer_if #(.CNT_W(CNT_W)) bus ();

    tt_phase_sequencer #(
        .CNT_W      (CNT_W),
        .DRIVE_CYC  (DRIVE_CYC),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [W-1:0] exp_q[$];
    logic [2:0]   stim_q[$];   // {start, abort, sample_ack} driven during that cycle
    int           vectors     = 0;
    int           miscompares = 0;
    string        cur_test;

    function automatic logic [W-1:0] obs_vec();
        return {bus.ch1_phi, bus.ch1_phib, bus.ch2_phi, bus.ch2_phib, bus.settle,
                bus.sample_req, bus.active_ch, bus.busy, bus.done, bus.phase_cnt};
    endfunction

    // Expected outputs for cycle k of a segment, written straight from the phase table.
    function automatic logic [W-1:0] mk(input tt_seq_state_e seg, input int k);
        logic drive, ch2, phi;
        logic [CNT_W-1:0] cnt;
        drive = (seg == ST_DRIVE1) || (seg == ST_DRIVE2);
        ch2   = (seg == ST_DRIVE2) || (seg == ST_SETTLE2) || (seg == ST_SAMPLE2);
        phi   = drive && (k % 2 == 0);
        cnt   = (seg == ST_IDLE) ? '0 : CNT_W'((k > CNT_MAX) ? CNT_MAX : k);
        return {phi && !ch2, drive && !phi && !ch2, phi && ch2, drive && !phi && ch2,
                (seg == ST_SETTLE1) || (seg == ST_SETTLE2),
                (seg == ST_SAMPLE1) || (seg == ST_SAMPLE2),
                ch2, seg != ST_IDLE, seg == ST_DONE, cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_idle(input int n, input logic st, input logic ab);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk(ST_IDLE, 0));
            stim_q.push_back({st, ab, 1'b0});
        end
    endtask

    // One start cycle followed by the full sequence, cut short after an abort cycle.
    task automatic add_sequence(input int ack_delay, input bit ack_early,
                                input tt_seq_state_e abort_st, input int abort_cyc,
                                input tt_seq_state_e start_st, input int start_cyc);
        tt_seq_state_e segs[$];
        int len;
        logic st, ab, ack;
        push_idle(1, 1'b1, 1'b0);
        segs = {ST_DRIVE1, ST_SETTLE1, ST_SAMPLE1};
`ifdef TT_CH2_EN
        segs.push_back(ST_DRIVE2);
        segs.push_back(ST_SETTLE2);
        segs.push_back(ST_SAMPLE2);
`endif
        segs.push_back(ST_DONE);
        foreach (segs[s]) begin
            case (segs[s])
                ST_DRIVE1, ST_DRIVE2:   len = DRIVE_CYC;
                ST_SETTLE1, ST_SETTLE2: len = SETTLE_CYC;
                ST_SAMPLE1, ST_SAMPLE2: len = ack_delay + 1;
                default:                len = 1;
            endcase
            for (int k = 0; k < len; k++) begin
                st  = (segs[s] == start_st) && (k == start_cyc);
                ab  = (segs[s] == abort_st) && (k == abort_cyc);
                if (segs[s] == ST_SAMPLE1 || segs[s] == ST_SAMPLE2)
                    ack = (k >= ack_delay);
                else
                    ack = ack_early && (segs[s] == ST_SETTLE1 || segs[s] == ST_SETTLE2) &&
                          (k == SETTLE_CYC - 1);
                exp_q.push_back(mk(segs[s], k));
                stim_q.push_back({st, ab, ack});
                if (ab) return;
            end
        end
    endtask

    task automatic run_queue();
        logic [W-1:0] exp_v, obs;
        int cyc = 0;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            {bus.start, bus.abort, bus.sample_ack} = stim_q.pop_front();
            obs = obs_vec();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %h expected %h", cur_test, cyc, obs, exp_v);
            end
            cyc++;
            tick();
        end
        {bus.start, bus.abort, bus.sample_ack} = 3'b000;
    endtask

    task automatic test_reset();
        logic [W-1:0] obs;
        cur_test = "reset";
        rst_n = 1'b0;
        {bus.start, bus.abort, bus.sample_ack} = 3'b000;
        #1;
        obs = obs_vec();
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_initial: got %h expected 0", obs);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        obs = obs_vec();
        vectors++;
        if (obs !== mk(ST_DRIVE1, 5)) begin
            miscompares++;
            $display("FAIL reset_pre_drive1: got %h expected %h", obs, mk(ST_DRIVE1, 5));
        end
        #2 rst_n = 1'b0;
        #1;
        obs = obs_vec();
        vectors++;
        if (obs !== '0 || bus.dbg_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_async: got %h state %0d expected 0 state 0", obs, bus.dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        obs = obs_vec();
        vectors++;
        if (obs !== '0 || bus.dbg_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_release: got %h state %0d expected 0 state 0", obs, bus.dbg_state);
        end
    endtask

    task automatic test_nominal();
        cur_test = "nominal";
        add_sequence(3, 1'b0, ST_IDLE, 0, ST_IDLE, 0);
        push_idle(2, 1'b0, 1'b0);
        run_queue();
    endtask

    task automatic test_ack_on_entry();
        cur_test = "ack_on_entry";
        add_sequence(0, 1'b1, ST_IDLE, 0, ST_IDLE, 0);
        push_idle(2, 1'b0, 1'b0);
        run_queue();
    endtask

    task automatic test_abort();
        cur_test = "abort";
`ifdef TT_CH2_EN
        add_sequence(1, 1'b0, ST_DRIVE2, 5, ST_IDLE, 0);
`else
        add_sequence(1, 1'b0, ST_DRIVE1, 5, ST_IDLE, 0);
`endif
        add_sequence(2, 1'b0, ST_SETTLE1, 3, ST_IDLE, 0);
        add_sequence(1, 1'b0, ST_IDLE, 0, ST_IDLE, 0);
        push_idle(2, 1'b0, 1'b0);
        run_queue();
    endtask

    task automatic test_ignored_start();
        cur_test = "ignored_start";
        push_idle(3, 1'b1, 1'b1);
        add_sequence(2, 1'b0, ST_IDLE, 0, ST_SETTLE1, 2);
        push_idle(1, 1'b0, 1'b0);
        add_sequence(1, 1'b0, ST_IDLE, 0, ST_DONE, 0);
        push_idle(3, 1'b0, 1'b0);
        run_queue();
    endtask

    task automatic test_cnt_saturation();
        cur_test = "cnt_saturation";
        add_sequence(CNT_MAX + 6, 1'b0, ST_IDLE, 0, ST_IDLE, 0);
        push_idle(2, 1'b0, 1'b0);
        run_queue();
    endtask

    task automatic test_back_to_back();
        cur_test = "back_to_back";
        add_sequence($urandom_range(0, 5), 1'b0, ST_IDLE, 0, ST_IDLE, 0);
        add_sequence($urandom_range(0, 5), 1'b1, ST_IDLE, 0, ST_IDLE, 0);
        push_idle(1, 1'b0, 1'b0);
        run_queue();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_ack_on_entry();
        test_abort();
        test_ignored_start();
        test_cnt_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
